smi_arbiter: RTL and testbench

Shares one smi_read_write MDIO engine between NUM_REQ independent requesters, e.g. link pollers, PHY init sequencer and a debug/CPU register port.
Each requester posts one read or write transaction. The arbiter grants round-robin, drives the engine's request pulses and routes the done/read data back to the granted requester.
Includes a response timeout so a stuck PHY cannot lock the bus. Sits between the smi_config-style clients and smi_read_write.

---
 rtl/smi_pkg.sv | 31 +++
 rtl/smi_rr_arb.sv | 38 +++
 rtl/smi_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_smi_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_pkg.sv
// Shared SMI/MDIO definitions: arbiter FSM encoding, latched command payload,
// error data pattern and the MDIO opcodes also used by smi_read_write.
package smi_pkg;

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned PHY_W  = 5;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 16;

   localparam logic [DATA_W-1:0] SMI_ERR_RDATA = 16'hFFFF;

   localparam logic [1:0] SMI_START    = 2'b01;
   localparam logic [1:0] SMI_OP_WRITE = 2'b01;
   localparam logic [1:0] SMI_OP_READ  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_GUARD
   } smi_state_e;

   typedef struct packed {
      logic              write;
      logic [PHY_W-1:0]  phy;
      logic [REG_W-1:0]  rga;
      logic [DATA_W-1:0] wdata;
   } smi_cmd_t;

endpackage

// File: rtl/smi_rr_arb.sv
// Combinational round-robin select: first set request at or after the pointer,
// wrapping to index 0.
module smi_rr_arb
   import smi_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant_c,
   output logic [IDX_W-1:0]   o_idx_c,
   output logic               o_valid_c
);

   always_comb begin : p_select
      logic found;
      found     = 1'b0;
      o_grant_c = '0;
      o_idx_c   = '0;
      // Segment [ptr, NUM_REQ) outranks the wrapped segment [0, ptr).
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && i_req[i] && (i >= 32'(i_ptr))) begin
            found        = 1'b1;
            o_grant_c[i] = 1'b1;
            o_idx_c      = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && i_req[i] && (i < 32'(i_ptr))) begin
            found        = 1'b1;
            o_grant_c[i] = 1'b1;
            o_idx_c      = IDX_W'(i);
         end
      end
      o_valid_c = found;
   end

endmodule

// File: rtl/smi_arbiter.sv
// Round-robin sharing of one smi_read_write engine between NUM_REQ requesters,
// with a response timeout and a guard period so a stuck PHY cannot lock the bus.
module smi_arbiter
   import smi_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 100000
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [PHY_W*NUM_REQ-1:0]  req_phy_addr,
   input  logic [REG_W*NUM_REQ-1:0]  req_reg_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      busy,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      smi_write_req,
   output logic                      smi_read_req,
   output logic [PHY_W-1:0]          smi_phy_addr,
   output logic [REG_W-1:0]          smi_reg_addr,
   output logic [DATA_W-1:0]         smi_write_data,
   input  logic [DATA_W-1:0]         smi_read_data,
   input  logic                      smi_data_valid,
   input  logic                      smi_done
);

   localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   smi_state_e          r_state,     w_state_nxt;
   logic [IDX_W-1:0]    r_ptr,       w_ptr_nxt;
   logic [TMR_W-1:0]    r_timer,     w_timer_nxt;
   smi_cmd_t            r_cmd,       w_cmd_nxt;
   logic [DATA_W-1:0]   r_rdata_cap, w_rdata_cap_nxt;
   logic [NUM_REQ-1:0]  r_grant_oh,  w_grant_oh_nxt;
   logic [NUM_REQ-1:0]  r_req_ready, w_req_ready_nxt;
   logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
   logic                r_rsp_err,   w_rsp_err_nxt;
   logic                r_busy,      w_busy_nxt;
   logic [IDX_W-1:0]    r_grant_id,  w_grant_id_nxt;
   logic                r_wr_req,    w_wr_req_nxt;
   logic                r_rd_req,    w_rd_req_nxt;

   logic [NUM_REQ-1:0]  w_arb_grant;
   logic [IDX_W-1:0]    w_arb_idx;
   logic                w_arb_valid;
   smi_cmd_t            w_cmd_arr [NUM_REQ];
   smi_cmd_t            w_sel_cmd;

   smi_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .o_grant_c (w_arb_grant),
      .o_idx_c   (w_arb_idx),
      .o_valid_c (w_arb_valid)
   );

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_cmd_arr[gi] = '{write: req_write[gi],
                               phy:   req_phy_addr[gi*PHY_W +: PHY_W],
                               rga:   req_reg_addr[gi*REG_W +: REG_W],
                               wdata: req_wdata[gi*DATA_W +: DATA_W]};
   end

   // One-hot mux of the winning requester's command fields.
   always_comb begin
      w_sel_cmd = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_arb_grant[i]) w_sel_cmd = w_cmd_arr[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_timer     <= '0;
         r_cmd       <= '0;
         r_rdata_cap <= '0;
         r_grant_oh  <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_grant_id  <= '0;
         r_wr_req    <= 1'b0;
         r_rd_req    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_timer     <= w_timer_nxt;
         r_cmd       <= w_cmd_nxt;
         r_rdata_cap <= w_rdata_cap_nxt;
         r_grant_oh  <= w_grant_oh_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_busy      <= w_busy_nxt;
         r_grant_id  <= w_grant_id_nxt;
         r_wr_req    <= w_wr_req_nxt;
         r_rd_req    <= w_rd_req_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_timer_nxt     = r_timer;
      w_cmd_nxt       = r_cmd;
      w_rdata_cap_nxt = r_rdata_cap;
      w_grant_oh_nxt  = r_grant_oh;
      w_req_ready_nxt = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_busy_nxt      = r_busy;
      w_grant_id_nxt  = r_grant_id;
      w_wr_req_nxt    = 1'b0;
      w_rd_req_nxt    = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_cmd_nxt       = w_sel_cmd;
               w_req_ready_nxt = w_arb_grant;
               w_grant_oh_nxt  = w_arb_grant;
               w_grant_id_nxt  = w_arb_idx;
               w_busy_nxt      = 1'b1;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_wr_req_nxt    = r_cmd.write;
            w_rd_req_nxt    = !r_cmd.write;
            w_timer_nxt     = '0;
            w_rdata_cap_nxt = '0;
            w_state_nxt     = ST_WAIT;
         end
         ST_WAIT: begin
            if (smi_data_valid) w_rdata_cap_nxt = smi_read_data;
            // Done outranks a coincident timeout.
            if (smi_done) begin
               w_rsp_valid_nxt = r_grant_oh;
               w_rsp_err_nxt   = 1'b0;
               if (r_cmd.write)         w_rsp_rdata_nxt = '0;
               else if (smi_data_valid) w_rsp_rdata_nxt = smi_read_data;
               else                     w_rsp_rdata_nxt = r_rdata_cap;
               w_state_nxt     = ST_RESP;
            end else if (r_timer == TMR_LAST) begin
               w_rsp_valid_nxt = r_grant_oh;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = SMI_ERR_RDATA;
               w_state_nxt     = ST_RESP;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         ST_RESP: begin
            w_ptr_nxt   = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
            w_timer_nxt = '0;
            if (r_rsp_err) begin
               w_state_nxt = ST_GUARD;
            end else begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GUARD: begin
            // Keep the engine quiet until the stuck transaction ends or ages out.
            if (smi_done || (r_timer == TMR_LAST)) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign req_ready      = r_req_ready;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_rdata      = r_rsp_rdata;
   assign rsp_err        = r_rsp_err;
   assign busy           = r_busy;
   assign grant_id       = r_grant_id;
   assign smi_write_req  = r_wr_req;
   assign smi_read_req   = r_rd_req;
   assign smi_phy_addr   = r_cmd.phy;
   assign smi_reg_addr   = r_cmd.rga;
   assign smi_write_data = r_cmd.wdata;

endmodule

// File: tb/tb_smi_arbiter.sv
// Scoreboard bench for smi_arbiter: a behavioural MDIO engine answers requests,
// expected transactions are queued in predicted grant order and checked on output.
module tb_smi_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 20;

   logic             clk;
   logic             rst;
   logic [NREQ-1:0]  req_valid, req_write;
   logic [5*NREQ-1:0]  req_phy_addr, req_reg_addr;
   logic [16*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]  req_ready, rsp_valid;
   logic [15:0]      rsp_rdata;
   logic             rsp_err, busy;
   logic [2:0]       grant_id;
   logic             smi_write_req, smi_read_req;
   logic [4:0]       smi_phy_addr, smi_reg_addr;
   logic [15:0]      smi_write_data, smi_read_data;
   logic             smi_data_valid, smi_done;

   smi_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_phy_addr   (req_phy_addr),
      .req_reg_addr   (req_reg_addr),
      .req_wdata      (req_wdata),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .busy           (busy),
      .grant_id       (grant_id),
      .smi_write_req  (smi_write_req),
      .smi_read_req   (smi_read_req),
      .smi_phy_addr   (smi_phy_addr),
      .smi_reg_addr   (smi_reg_addr),
      .smi_write_data (smi_write_data),
      .smi_read_data  (smi_read_data),
      .smi_data_valid (smi_data_valid),
      .smi_done       (smi_done)
   );

   typedef struct {
      int          id;
      bit          wr;
      logic [4:0]  phy;
      logic [4:0]  rga;
      logic [15:0] wdata;
      logic [15:0] rdata;
      bit          err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
   bit   guard_chk = 0;
   bit   eng_active = 0, eng_stall = 0, eng_wr = 0;
   int   eng_cnt = 0;
   logic [4:0] eng_phy, eng_rga;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] rd_value(input logic [4:0] p, input logic [4:0] r);
      return (p == 5'd1 && r == 5'd17) ? 16'hAC00 : {p, r, 6'h2A};
   endfunction

   task automatic push_exp(input int id, input bit wr, input logic [4:0] p, input logic [4:0] r,
                           input logic [15:0] wd, input bit err);
      exp_t e;
      e.id = id; e.wr = wr; e.phy = p; e.rga = r; e.wdata = wd; e.err = err;
      e.rdata = err ? 16'hFFFF : (wr ? 16'h0000 : rd_value(p, r));
      q.push_back(e);
   endtask

   task automatic post(input int id, input bit wr, input logic [4:0] p, input logic [4:0] r,
                       input logic [15:0] wd);
      req_write[id]           = wr;
      req_phy_addr[id*5 +: 5] = p;
      req_reg_addr[id*5 +: 5] = r;
      req_wdata[id*16 +: 16]  = wd;
      req_valid[id]           = 1'b1;
   endtask

   task automatic check_outs_zero(input string tag);
      check(tag, {req_ready, rsp_valid, rsp_rdata, rsp_err, busy, grant_id, smi_write_req,
                  smi_read_req, smi_phy_addr, smi_reg_addr, smi_write_data}, 64'd0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((q.size() != 0 || busy || req_valid != '0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, 64'(q.size()), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      q.delete();
      eng_active = 0; eng_cnt = 0; eng_stall = 0; guard_chk = 0;
      repeat (2) @(negedge clk);
      check_outs_zero("reset_outs");
      rst = 1'b0;
   endtask

   // Monitor, scoreboard and engine model share one negedge process to avoid races.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         smi_done = 1'b0; smi_data_valid = 1'b0; smi_read_data = 16'h5555;
         if (rst) continue;

         if (req_ready != '0) begin
            if (q.size() == 0) check("ready_unexp", 64'(req_ready), 64'd0);
            else begin
               e = q[0];
               check("ready_oh", 64'(req_ready), 64'd1 << e.id);
               check("grant_id", 64'(grant_id), 64'(e.id));
               check("busy_acc", 64'(busy), 64'd1);
               if (guard_chk) begin
                  check("guard_wait", 64'(cyc - err_cyc), 64'(TO + 2));
                  guard_chk = 0;
               end
            end
            acc_cyc = cyc;
            req_valid = req_valid & ~req_ready;
         end

         if (smi_read_req || smi_write_req) begin
            check("eng_overlap", 64'(eng_active), 64'd0);
            if (q.size() != 0) begin
               e = q[0];
               check("req_op", 64'({smi_write_req, smi_read_req}), e.wr ? 64'd2 : 64'd1);
               check("req_phy", 64'(smi_phy_addr), 64'(e.phy));
               check("req_reg", 64'(smi_reg_addr), 64'(e.rga));
               if (e.wr) check("req_wdata", 64'(smi_write_data), 64'(e.wdata));
               check("acc2req", 64'(cyc - acc_cyc), 64'd1);
            end
            eng_active = 1; eng_wr = smi_write_req;
            eng_phy = smi_phy_addr; eng_rga = smi_reg_addr;
            eng_cnt = eng_stall ? 0 : 4;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 2 && !eng_wr) begin
               smi_data_valid = 1'b1;
               smi_read_data  = rd_value(eng_phy, eng_rga);
            end
            if (eng_cnt == 0) begin
               smi_done = 1'b1; eng_active = 0; done_cyc = cyc;
            end
         end

         if (rsp_valid != '0) begin
            if (q.size() == 0) check("rsp_unexp", 64'(rsp_valid), 64'd0);
            else begin
               e = q.pop_front();
               check("rsp_oh", 64'(rsp_valid), 64'd1 << e.id);
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_err", 64'(rsp_err), 64'(e.err));
               check("busy_rsp", 64'(busy), 64'd1);
               if (e.err) begin
                  check("timeout_lat", 64'(cyc - acc_cyc), 64'(TO + 1));
                  eng_active = 0; eng_stall = 0; err_cyc = cyc;
               end else begin
                  check("done2rsp", 64'(cyc - done_cyc), 64'd1);
               end
            end
         end
      end
   end

   initial begin : main
      int n;
      rst = 1'b1;
      req_valid = '0; req_write = '0; req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0;
      smi_read_data = '0; smi_data_valid = 1'b0; smi_done = 1'b0;
      repeat (3) @(negedge clk);
      check_outs_zero("por_outs");
      rst = 1'b0;

      // single read, requester 0
      push_exp(0, 0, 5'd1, 5'd17, 16'h0, 0);
      post(0, 0, 5'd1, 5'd17, 16'h0);
      wait_idle("read0");

      // single write, requester 2
      push_exp(2, 1, 5'd1, 5'd0, 16'h2100, 0);
      post(2, 1, 5'd1, 5'd0, 16'h2100);
      wait_idle("write2");

      // all four from reset: order 0,1,2,3
      do_reset();
      for (int i = 0; i < NREQ; i++) push_exp(i, i[0], 5'(i + 4), 5'(i * 3), 16'(16'h1000 + i), 0);
      for (int i = 0; i < NREQ; i++) post(i, i[0], 5'(i + 4), 5'(i * 3), 16'(16'h1000 + i));
      wait_idle("all4");

      // fairness: grant 2 moves pointer to 3, then 3 beats 1
      push_exp(2, 0, 5'd7, 5'd2, 16'h0, 0);
      post(2, 0, 5'd7, 5'd2, 16'h0);
      wait_idle("fair_a");
      push_exp(3, 1, 5'd9, 5'd4, 16'hBEEF, 0);
      push_exp(1, 0, 5'd8, 5'd5, 16'h0, 0);
      post(1, 0, 5'd8, 5'd5, 16'h0);
      post(3, 1, 5'd9, 5'd4, 16'hBEEF);
      wait_idle("fair_b");

      // timeout on requester 1, requester 2 held off until the guard expires
      eng_stall = 1;
      push_exp(1, 0, 5'd3, 5'd2, 16'h0, 1);
      post(1, 0, 5'd3, 5'd2, 16'h0);
      n = 0;
      while (req_valid[1] && n < 100) begin @(negedge clk); n++; end
      check("to_accept", 64'(req_valid[1]), 64'd0);
      push_exp(2, 0, 5'd6, 5'd11, 16'h0, 0);
      post(2, 0, 5'd6, 5'd11, 16'h0);
      guard_chk = 1;
      wait_idle("timeout");
      check("guard_seen", 64'(guard_chk), 64'd0);

      // reset mid-WAIT aborts silently and rewinds the pointer
      eng_stall = 1;
      push_exp(3, 0, 5'd2, 5'd3, 16'h0, 0);
      post(3, 0, 5'd2, 5'd3, 16'h0);
      n = 0;
      while (!eng_active && n < 100) begin @(negedge clk); n++; end
      check("mid_issue", 64'(eng_active), 64'd1);
      repeat (3) @(negedge clk);
      do_reset();
      push_exp(1, 0, 5'd1, 5'd17, 16'h0, 0);
      push_exp(3, 1, 5'd4, 5'd9, 16'h0F0F, 0);
      post(1, 0, 5'd1, 5'd17, 16'h0);
      post(3, 1, 5'd4, 5'd9, 16'h0F0F);
      wait_idle("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1);
   end

endmodule
